// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, branch and forward-select encodings,
// instruction field positions and the per-opcode control bundle.
package decode_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b101010;
  localparam logic [5:0] OPC_LD    = 6'b100000;
  localparam logic [5:0] OPC_SD    = 6'b100001;
  localparam logic [5:0] OPC_VBEZ  = 6'b100011;
  localparam logic [5:0] OPC_VBNZ  = 6'b100010;
  localparam logic [5:0] OPC_NOP   = 6'b111100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EZ   = 2'b01;
  localparam logic [1:0] BR_NZ   = 2'b10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int OPC_LSB = 26;
  localparam int RD_LSB  = 21;
  localparam int RA_LSB  = 16;
  localparam int RB_LSB  = 11;
  localparam int PPP_LSB = 8;
  localparam int WW_LSB  = 6;
  localparam int FN_LSB  = 0;

  typedef struct packed {
    logic       wr_en;
    logic       mem_en;
    logic       store_en;
    logic       load;
    logic [1:0] br;
    logic       use_a;
    logic       use_b;
    logic       a_is_rd;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_hazard_stage_if.sv
// IF->ID->EX bundle: fetch inputs, stall/read-port outputs, ID/EX register.
// master drives fetch side, slave is the decode stage. Macro: FORWARDING_EN.
interface decode_hazard_stage_if #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16
);
  logic                  if_valid;
  logic [INSTR_W-1:0]    if_instr;
  logic                  flush;
  logic                  id_stall;
  logic [REG_ADDR_W-1:0] rf_addr_a;
  logic [REG_ADDR_W-1:0] rf_addr_b;
  logic                  ex_valid;
  logic [5:0]            ex_op;
  logic [1:0]            ex_ww;
  logic [2:0]            ex_ppp;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_wr_en;
  logic                  ex_mem_en;
  logic                  ex_store_en;
  logic                  ex_load;
  logic [1:0]            ex_br;
  logic [IMM_W-1:0]      ex_imm;
  logic                  illegal_op;
`ifdef FORWARDING_EN
  logic [1:0]            ex_fwd_a;
  logic [1:0]            ex_fwd_b;
`endif

  modport master (
    output if_valid, if_instr, flush,
`ifdef FORWARDING_EN
    input  ex_fwd_a, ex_fwd_b,
`endif
    input  id_stall, rf_addr_a, rf_addr_b,
    input  ex_valid, ex_op, ex_ww, ex_ppp, ex_rd,
    input  ex_wr_en, ex_mem_en, ex_store_en, ex_load,
    input  ex_br, ex_imm, illegal_op
  );

  modport slave (
    input  if_valid, if_instr, flush,
`ifdef FORWARDING_EN
    output ex_fwd_a, ex_fwd_b,
`endif
    output id_stall, rf_addr_a, rf_addr_b,
    output ex_valid, ex_op, ex_ww, ex_ppp, ex_rd,
    output ex_wr_en, ex_mem_en, ex_store_en, ex_load,
    output ex_br, ex_imm, illegal_op
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight writer shift register (entry 0 = EX) and RAW match logic.
// Ports: push side from ID issue, source regs, hazard (+fwd if FORWARDING_EN).
module hazard_scoreboard
  import decode_pkg::*;
#(
  parameter int HAZ_DEPTH  = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic                  use_a,
  input  logic                  use_b,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
`ifdef FORWARDING_EN
  input  logic                  push_load,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
`endif
  output logic                  hazard
);

  logic [HAZ_DEPTH-1:0]  vld;
  logic [REG_ADDR_W-1:0] rd_q [HAZ_DEPTH];
  logic [HAZ_DEPTH-1:0]  m_a;
  logic [HAZ_DEPTH-1:0]  m_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      for (int i = HAZ_DEPTH-1; i > 0; i--)
        vld[i] <= vld[i-1];
      vld[0] <= push;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = HAZ_DEPTH-1; i > 0; i--)
      rd_q[i] <= rd_q[i-1];
    rd_q[0] <= push_rd;
  end

  always_comb begin
    m_a = '0;
    m_b = '0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      m_a[i] = use_a & vld[i] & (rd_q[i] == src_a);
      m_b[i] = use_b & vld[i] & (rd_q[i] == src_b);
    end
  end

`ifdef FORWARDING_EN
  logic [HAZ_DEPTH-1:0] ld_q;
  logic [2:0]           res_a;
  logic [2:0]           res_b;

  always_ff @(posedge clk) begin
    for (int i = HAZ_DEPTH-1; i > 0; i--)
      ld_q[i] <= ld_q[i-1];
    ld_q[0] <= push_load;
  end

  // {stall, sel}; walk oldest to youngest so the youngest match wins
  function automatic logic [2:0] resolve(
    input logic [HAZ_DEPTH-1:0] m,
    input logic                 ld0
  );
    logic [2:0] r;
    r = {1'b0, FWD_NONE};
    for (int i = HAZ_DEPTH-1; i >= 0; i--) begin
      if (m[i]) begin
        if (i == 0)
          r = ld0 ? {1'b1, FWD_NONE} : {1'b0, FWD_EX};
        else if (i == 1)
          r = {1'b0, FWD_MEM};
        else
          r = {1'b1, FWD_NONE};
      end
    end
    return r;
  endfunction

  assign res_a  = resolve(m_a, ld_q[0]);
  assign res_b  = resolve(m_b, ld_q[0]);
  assign fwd_a  = res_a[1:0];
  assign fwd_b  = res_b[1:0];
  assign hazard = if_valid & (res_a[2] | res_b[2]);
`else
  assign hazard = if_valid & (|m_a | |m_b);
`endif

endmodule

// File: rtl/decode_hazard_stage.sv
// Registered ID stage: decode, RAW stall, bubble insert, EX flush.
// Ports: clk, reset, bus (slave). Optional macro: FORWARDING_EN.
module decode_hazard_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 16,
  parameter int HAZ_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  decode_hazard_stage_if.slave  bus
);

  logic [INSTR_W-1:0]    ins;
  logic [5:0]            opc;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] ra;
  logic [REG_ADDR_W-1:0] rb;
  ctrl_t                 c;
  logic                  hazard;
  logic                  issue;

  assign ins = bus.if_instr;
  assign opc = ins[OPC_LSB +: 6];
  assign rd  = ins[RD_LSB +: REG_ADDR_W];
  assign ra  = ins[RA_LSB +: REG_ADDR_W];
  assign rb  = ins[RB_LSB +: REG_ADDR_W];

  always_comb begin
    c = '0;
    unique case (1'b1)
      opc == OPC_RTYPE: begin
        c.wr_en = 1'b1;
        c.use_a = 1'b1;
        c.use_b = 1'b1;
      end
      opc == OPC_LD: begin
        c.wr_en  = 1'b1;
        c.mem_en = 1'b1;
        c.load   = 1'b1;
      end
      opc == OPC_SD: begin
        c.mem_en   = 1'b1;
        c.store_en = 1'b1;
        c.use_a    = 1'b1;
        c.a_is_rd  = 1'b1;
      end
      opc == OPC_VBEZ: begin
        c.br      = BR_EZ;
        c.use_a   = 1'b1;
        c.a_is_rd = 1'b1;
      end
      opc == OPC_VBNZ: begin
        c.br      = BR_NZ;
        c.use_a   = 1'b1;
        c.a_is_rd = 1'b1;
      end
      opc == OPC_NOP: ;
      default: c.illegal = 1'b1;
    endcase
  end

  assign bus.rf_addr_a = c.a_is_rd ? rd : ra;
  assign bus.rf_addr_b = rb;

`ifdef FORWARDING_EN
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
`endif

  hazard_scoreboard #(
    .HAZ_DEPTH  (HAZ_DEPTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (bus.if_valid),
    .use_a     (c.use_a),
    .use_b     (c.use_b),
    .src_a     (bus.rf_addr_a),
    .src_b     (bus.rf_addr_b),
    .push      (issue & c.wr_en),
    .push_rd   (rd),
`ifdef FORWARDING_EN
    .push_load (c.load),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
`endif
    .hazard    (hazard)
  );

  // flush outranks hazard: the killed instruction must not hold fetch
  assign issue        = bus.if_valid & ~bus.flush & ~hazard;
  assign bus.id_stall = hazard & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_op       <= '0;
      bus.ex_ww       <= '0;
      bus.ex_ppp      <= '0;
      bus.ex_rd       <= '0;
      bus.ex_wr_en    <= 1'b0;
      bus.ex_mem_en   <= 1'b0;
      bus.ex_store_en <= 1'b0;
      bus.ex_load     <= 1'b0;
      bus.ex_br       <= BR_NONE;
      bus.ex_imm      <= '0;
      bus.illegal_op  <= 1'b0;
`ifdef FORWARDING_EN
      bus.ex_fwd_a    <= FWD_NONE;
      bus.ex_fwd_b    <= FWD_NONE;
`endif
    end else begin
      bus.ex_valid    <= 1'b1;
      bus.ex_op       <= ins[FN_LSB +: 6];
      bus.ex_ww       <= ins[WW_LSB +: 2];
      bus.ex_ppp      <= ins[PPP_LSB +: 3];
      bus.ex_rd       <= rd;
      bus.ex_wr_en    <= c.wr_en;
      bus.ex_mem_en   <= c.mem_en;
      bus.ex_store_en <= c.store_en;
      bus.ex_load     <= c.load;
      bus.ex_br       <= c.br;
      bus.ex_imm      <= ins[IMM_W-1:0];
      bus.illegal_op  <= c.illegal;
`ifdef FORWARDING_EN
      bus.ex_fwd_a    <= fwd_a;
      bus.ex_fwd_b    <= fwd_b;
`endif
    end
  end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Bench for decode_hazard_stage: directed vector table, forwarding
// sequences (FORWARDING_EN) and random stimulus against a writer-age model.
module tb_decode_hazard_stage;

  localparam int HD = 2;
  localparam logic [5:0] RT  = 6'b101010;
  localparam logic [5:0] LD  = 6'b100000;
  localparam logic [5:0] SD  = 6'b100001;
  localparam logic [5:0] BEZ = 6'b100011;
  localparam logic [5:0] BNZ = 6'b100010;
  localparam logic [5:0] NP  = 6'b111100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decode_hazard_stage_if bus();

  decode_hazard_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int fails  = 0;
  bit mchk   = 1'b0;
  logic        obs_stall;
  logic [28:0] obs_ex;
  logic [28:0] exp_ex;
  logic [1:0]  exp_fa;
  logic [1:0]  exp_fb;

  // in-flight writers; age 1 = instruction currently in EX
  typedef struct {
    logic [4:0] rd;
    bit         ld;
    int         age;
  } wr_t;
  wr_t q[$];

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] ins;
    bit          fl;
    bit          stall;
    logic [28:0] ex;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, want);
    end
  endtask

  function automatic logic [28:0] pack_dut();
    return {bus.ex_valid, bus.ex_rd, bus.ex_wr_en, bus.ex_mem_en,
            bus.ex_store_en, bus.ex_load, bus.ex_br, bus.ex_imm,
            bus.illegal_op};
  endfunction

  // {stall, fwd_sel} for one used source register
  function automatic logic [2:0] src_stat(logic [4:0] s);
    int best = 0;
    bit bl = 1'b0;
    foreach (q[i])
      if (q[i].rd == s && (best == 0 || q[i].age < best)) begin
        best = q[i].age;
        bl   = q[i].ld;
      end
    if (best == 0) return 3'b000;
`ifdef FORWARDING_EN
    if (best == 1) return bl ? 3'b100 : 3'b001;
    if (best == 2) return 3'b010;
    return 3'b100;
`else
    return 3'b100;
`endif
  endfunction

  task automatic cycle(input bit r, input bit v,
                       input logic [31:0] ins, input bit f);
    logic [5:0] opc;
    logic [4:0] rd, ra, rb, ea;
    logic [1:0] br;
    logic [2:0] sa, sb;
    bit wr, mem, st, ld, ill, ua, ub, ard, hz, iss;
    opc = ins[31:26];
    rd  = ins[25:21];
    ra  = ins[20:16];
    rb  = ins[15:11];
    {wr, mem, st, ld, ill, ua, ub, ard} = '0;
    br = 2'b00;
    case (opc)
      RT:  begin wr = 1; ua = 1; ub = 1; end
      LD:  begin wr = 1; mem = 1; ld = 1; end
      SD:  begin mem = 1; st = 1; ua = 1; ard = 1; end
      BEZ: begin br = 2'b01; ua = 1; ard = 1; end
      BNZ: begin br = 2'b10; ua = 1; ard = 1; end
      NP:  ;
      default: ill = 1;
    endcase
    ea  = ard ? rd : ra;
    sa  = ua ? src_stat(ea) : 3'b000;
    sb  = ub ? src_stat(rb) : 3'b000;
    hz  = v && (sa[2] || sb[2]);
    iss = v && !f && !hz;

    @(negedge clk);
    reset        = r;
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.flush    = f;
    #1;
    obs_stall = bus.id_stall;
    if (mchk) begin
      chk("id_stall", {31'd0, obs_stall}, {31'd0, hz && !f});
      chk("rf_addr_a", {27'd0, bus.rf_addr_a}, {27'd0, ea});
      chk("rf_addr_b", {27'd0, bus.rf_addr_b}, {27'd0, rb});
    end

    @(posedge clk);
    if (r) begin
      q.delete();
      exp_ex = '0;
      exp_fa = 2'b00;
      exp_fb = 2'b00;
    end else begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[$].age > HD) void'(q.pop_back());
      if (iss && wr) q.push_front('{rd, ld, 1});
      exp_ex = iss ? {1'b1, rd, wr, mem, st, ld, br, ins[15:0], ill}
                   : 29'd0;
      exp_fa = iss ? sa[1:0] : 2'b00;
      exp_fb = iss ? sb[1:0] : 2'b00;
    end
    #1;
    obs_ex = pack_dut();
    if (mchk) begin
      chk("ex_bundle", {3'd0, obs_ex}, {3'd0, exp_ex});
      chk("ex_fields", {21'd0, bus.ex_ppp, bus.ex_ww, bus.ex_op},
          {21'd0, iss && !r ? ins[10:0] : 11'd0});
`ifdef FORWARDING_EN
      chk("ex_fwd_a", {30'd0, bus.ex_fwd_a}, {30'd0, exp_fa});
      chk("ex_fwd_b", {30'd0, bus.ex_fwd_b}, {30'd0, exp_fb});
`endif
    end
  endtask

  function automatic logic [31:0] R(int rd, int ra, int rb);
    return {RT, 5'(rd), 5'(ra), 5'(rb), 11'd0};
  endfunction

  function automatic logic [31:0] I(logic [5:0] o, int rd,
                                    logic [15:0] imm);
    return {o, 5'(rd), 5'd0, imm};
  endfunction

  function automatic logic [28:0] XR(int rd, int rb);
    return {1'b1, 5'(rd), 4'b1000, 2'b00, 5'(rb), 11'd0, 1'b0};
  endfunction

  task automatic add(bit r, bit v, logic [31:0] ins, bit f,
                     bit s, logic [28:0] ex);
    tbl.push_back('{r, v, ins, f, s, ex});
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  o;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.flush    = 1'b0;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    mchk = 1'b1;

`ifndef FORWARDING_EN
    add(1, 1, R(3,1,2), 0, 0, 29'd0);
    add(0, 1, R(3,1,2), 0, 0, XR(3,2));
    add(0, 1, R(4,6,7), 0, 0, XR(4,7));
    add(0, 0, 0, 0, 0, 29'd0);
    add(0, 0, 0, 0, 0, 29'd0);
    add(0, 1, R(3,1,2), 0, 0, XR(3,2));
    add(0, 1, R(8,3,9), 0, 1, 29'd0);
    add(0, 1, R(8,3,9), 0, 1, 29'd0);
    add(0, 1, R(8,3,9), 0, 0, XR(8,9));
    add(0, 0, 0, 0, 0, 29'd0);
    add(0, 0, 0, 0, 0, 29'd0);
    add(0, 1, I(LD,5,16'h0010), 0, 0,
        {1'b1, 5'd5, 4'b1101, 2'b00, 16'h0010, 1'b0});
    add(0, 1, I(BNZ,5,16'h0040), 0, 1, 29'd0);
    add(0, 1, I(BNZ,5,16'h0040), 0, 1, 29'd0);
    add(0, 1, I(BNZ,5,16'h0040), 0, 0,
        {1'b1, 5'd5, 4'b0000, 2'b10, 16'h0040, 1'b0});
    add(0, 1, R(3,1,2), 0, 0, XR(3,2));
    add(0, 1, R(9,3,3), 0, 1, 29'd0);
    add(0, 1, R(9,3,3), 1, 0, 29'd0);
    add(0, 1, R(9,3,3), 0, 0, XR(9,3));
    add(0, 0, 0, 0, 0, 29'd0);
    add(0, 0, 0, 0, 0, 29'd0);
    add(0, 1, I(6'b000000,7,16'h1234), 0, 0,
        {1'b1, 5'd7, 4'b0000, 2'b00, 16'h1234, 1'b1});
    add(0, 1, I(NP,7,16'h0055), 0, 0,
        {1'b1, 5'd7, 4'b0000, 2'b00, 16'h0055, 1'b0});
    add(0, 1, R(3,1,2), 0, 0, XR(3,2));
    add(0, 1, R(8,3,9), 0, 1, 29'd0);
    add(1, 1, R(8,3,9), 0, 1, 29'd0);
    add(0, 1, R(8,3,9), 0, 0, XR(8,9));
    add(0, 1, I(SD,8,16'h0020), 0, 1, 29'd0);
    add(0, 1, I(SD,8,16'h0020), 0, 1, 29'd0);
    add(0, 1, I(SD,8,16'h0020), 0, 0,
        {1'b1, 5'd8, 4'b0110, 2'b00, 16'h0020, 1'b0});
    add(0, 1, I(BEZ,2,16'h0003), 0, 0,
        {1'b1, 5'd2, 4'b0000, 2'b01, 16'h0003, 1'b0});
    add(0, 0, 0, 0, 0, 29'd0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].ins, tbl[i].fl);
      chk($sformatf("tbl%0d_stall", i), {31'd0, obs_stall},
          {31'd0, tbl[i].stall});
      chk($sformatf("tbl%0d_ex", i), {3'd0, obs_ex}, {3'd0, tbl[i].ex});
    end
`else
    cycle(1, 0, 0, 0);
    cycle(0, 1, R(3,1,2), 0);
    cycle(0, 1, R(8,3,9), 0);
    chk("fwd_ex_nostall", {31'd0, obs_stall}, 32'd0);
    chk("fwd_ex_sel", {30'd0, bus.ex_fwd_a}, 32'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, I(LD,5,16'h0010), 0);
    chk("fwd_ld_imm", {16'd0, bus.ex_imm}, 32'h0010);
    cycle(0, 1, I(BNZ,5,16'h0040), 0);
    chk("fwd_loaduse_stall", {31'd0, obs_stall}, 32'd1);
    cycle(0, 1, I(BNZ,5,16'h0040), 0);
    chk("fwd_mem_nostall", {31'd0, obs_stall}, 32'd0);
    chk("fwd_mem_br", {30'd0, bus.ex_br}, 32'd2);
    chk("fwd_mem_sel", {30'd0, bus.ex_fwd_a}, 32'd2);
`endif

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 6))
        0: o = RT;
        1: o = LD;
        2: o = SD;
        3: o = BEZ;
        4: o = BNZ;
        5: o = NP;
        default: o = 6'($urandom);
      endcase
      ins        = $urandom;
      ins[31:26] = o;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      ins[15:11] = 5'($urandom_range(0, 3));
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
            ins, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
